// File: rtl/ahb_mem_slave.sv
// AHB-Lite memory responder: word-organised on-chip RAM with byte/half/word lanes,
// a fixed number of data-phase wait states and a two-cycle ERROR response.
module ahb_mem_slave #(
  parameter int          ADDR_BITS   = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic        HWRITE,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [31:0] HWDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          TOP = ADDR_BITS + 2;
  localparam logic [3:0]  WS  = 4'(WAIT_STATES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  state_e                 state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [ADDR_BITS-1:0]   addr_q, addr_d;
  logic [1:0]             off_q, off_d;
  logic [2:0]             size_q, size_d;
  logic                   write_q, write_d;
  logic [31:0]            hrdata_q;
  logic [31:0]            mem_q [0:(1<<ADDR_BITS)-1];

  logic                   accept;
  logic                   illegal;
  logic                   commit;
  logic                   loadRead;
  logic [3:0]             byteEn;
  logic [31:0]            wrMerged;
  logic [ADDR_BITS-1:0]   rdIdx;
  logic [31:0]            rdWord;
  logic                   unusedOk;

  assign unusedOk = ^{HBURST, HTRANS[0]};

  assign HREADY = (state_q == ST_IDLE) || (state_q == ST_DATA) || (state_q == ST_ERR2);
  assign HRESP  = ((state_q == ST_ERR1) || (state_q == ST_ERR2)) ? 2'b01 : 2'b00;
  assign HRDATA = hrdata_q;

  assign accept  = HSEL && HTRANS[1] && HREADY;
  assign illegal = (HADDR[31:TOP] != BASE_ADDR[31:TOP]) ||
                   (HSIZE > 3'd2) ||
                   ((HSIZE == 3'd1) && HADDR[0]) ||
                   ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    off_d   = off_q;
    size_d  = size_q;
    write_d = write_q;
    case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd1) state_d = ST_DATA;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        // IDLE, DATA and ERR2 all have HREADY high, so each can open a new transfer
        state_d = ST_IDLE;
        if (accept) begin
          addr_d  = HADDR[TOP-1:2];
          off_d   = HADDR[1:0];
          size_d  = HSIZE;
          write_d = HWRITE;
          if (illegal) begin
            state_d = ST_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_DATA;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WS;
          end
        end
      end
    endcase
  end

  always_comb begin
    byteEn = 4'b1111;
    case (size_q)
      3'd0:    byteEn = 4'b0001 << off_q;
      3'd1:    byteEn = off_q[1] ? 4'b1100 : 4'b0011;
      default: byteEn = 4'b1111;
    endcase
  end

  always_comb begin
    wrMerged = mem_q[addr_q];
    for (int b = 0; b < 4; b++) begin
      if (byteEn[b]) wrMerged[8*b +: 8] = HWDATA[8*b +: 8];
    end
  end

  assign commit = (state_q == ST_DATA) && write_q;

  // A read enters DATA either straight from acceptance or from the last wait cycle;
  // a write committing at that same edge to the same word is forwarded.
  assign loadRead = ((state_q == ST_WAIT) && (cnt_q == 4'd1) && !write_q) ||
                    (accept && !illegal && !HWRITE && (WAIT_STATES == 0));
  assign rdIdx    = (state_q == ST_WAIT) ? addr_q : HADDR[TOP-1:2];
  assign rdWord   = (commit && (rdIdx == addr_q)) ? wrMerged : mem_q[rdIdx];

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      off_q    <= 2'b00;
      size_q   <= 3'd0;
      write_q  <= 1'b0;
      hrdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      off_q   <= off_d;
      size_q  <= size_d;
      write_q <= write_d;
      if (loadRead) hrdata_q <= rdWord;
    end
  end

  // Storage is never cleared; reset only suppresses a write still in flight
  always_ff @(posedge HCLK) begin
    if (!HRESET && commit) mem_q[addr_q] <= wrMerged;
  end

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench for ahb_mem_slave: one instance with no wait states, one with two,
// sharing the address/control/data drivers and selected by their own HSEL.
module tb_ahb_mem_slave;

  logic        HCLK;
  logic        HRESET;
  logic        HSEL0, HSEL2;
  logic [31:0] HADDR;
  logic        HWRITE;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [2:0]  HBURST;
  logic [31:0] HWDATA;
  logic        HREADY0, HREADY2;
  logic [1:0]  HRESP0, HRESP2;
  logic [31:0] HRDATA0, HRDATA2;

  int nAsserts = 0;
  int nFail    = 0;

  int          waits;
  logic [1:0]  firstResp, lastResp;
  logic [31:0] rdata;

  ahb_mem_slave #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(0)) uWs0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL0), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY0), .HRESP(HRESP0), .HRDATA(HRDATA0)
  );

  ahb_mem_slave #(.ADDR_BITS(10), .BASE_ADDR(32'h0), .WAIT_STATES(2)) uWs2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL2), .HADDR(HADDR), .HWRITE(HWRITE),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
    .HREADY(HREADY2), .HRESP(HRESP2), .HRDATA(HRDATA2)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  function automatic logic rdyOf(input int inst);
    return (inst == 0) ? HREADY0 : HREADY2;
  endfunction

  function automatic logic [1:0] respOf(input int inst);
    return (inst == 0) ? HRESP0 : HRESP2;
  endfunction

  function automatic logic [31:0] rdataOf(input int inst);
    return (inst == 0) ? HRDATA0 : HRDATA2;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Starts at a negedge with HREADY high: drives one NONSEQ address phase, then
  // follows the data phase to its final (HREADY high) cycle and returns there, so the
  // next call's address phase overlaps this data phase exactly as a pipelined master would.
  task automatic applyStimulus(input int inst, input logic wr, input logic [31:0] addr,
                               input logic [2:0] size, input logic [31:0] wdata,
                               output int nWait, output logic [1:0] resp1,
                               output logic [1:0] respN, output logic [31:0] rd);
    HSEL0  = (inst == 0);
    HSEL2  = (inst == 2);
    HADDR  = addr;
    HWRITE = wr;
    HSIZE  = size;
    HTRANS = 2'b10;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL0  = 1'b0;
    HSEL2  = 1'b0;
    HTRANS = 2'b00;
    HWDATA = wdata;
    nWait  = 0;
    resp1  = respOf(inst);
    while (!rdyOf(inst) && nWait < 40) begin
      nWait++;
      @(negedge HCLK);
    end
    if (!rdyOf(inst)) begin
      nAsserts++;
      nFail++;
      $error("[TB] FAIL timeout: HREADY observed %b expected 1 within 40 cycles", rdyOf(inst));
    end
    respN = respOf(inst);
    rd    = rdataOf(inst);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time observed 200000 expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    HRESET = 1'b1;
    HSEL0  = 1'b0;
    HSEL2  = 1'b0;
    HADDR  = 32'h0;
    HWRITE = 1'b0;
    HTRANS = 2'b00;
    HSIZE  = 3'd2;
    HBURST = 3'd0;
    HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;

    checkOutput("rst_hready0", {31'b0, HREADY0}, 32'd1);
    checkOutput("rst_hresp0",  {30'b0, HRESP0},  32'd0);
    checkOutput("rst_hrdata0", HRDATA0,          32'h0);
    checkOutput("rst_hready2", {31'b0, HREADY2}, 32'd1);
    checkOutput("rst_hresp2",  {30'b0, HRESP2},  32'd0);
    checkOutput("rst_hrdata2", HRDATA2,          32'h0);

    // zero wait states: write then pipelined read of the same word
    applyStimulus(0, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, waits, firstResp, lastResp, rdata);
    checkOutput("ws0_wr_waits", waits, 0);
    checkOutput("ws0_wr_resp", {30'b0, lastResp}, 32'd0);
    applyStimulus(0, 1'b0, 32'h10, 3'd2, 32'h0, waits, firstResp, lastResp, rdata);
    checkOutput("ws0_rd_waits", waits, 0);
    checkOutput("ws0_rd_data", rdata, 32'hDEADBEEF);
    checkOutput("ws0_rd_resp", {30'b0, lastResp}, 32'd0);

    // lane merge: word, byte at lane 2, low half, then readback
    applyStimulus(0, 1'b1, 32'h20, 3'd2, 32'h11223344, waits, firstResp, lastResp, rdata);
    applyStimulus(0, 1'b1, 32'h22, 3'd0, 32'h00AA0000, waits, firstResp, lastResp, rdata);
    applyStimulus(0, 1'b1, 32'h20, 3'd1, 32'h0000BEEF, waits, firstResp, lastResp, rdata);
    applyStimulus(0, 1'b0, 32'h20, 3'd2, 32'h0, waits, firstResp, lastResp, rdata);
    checkOutput("merge_rd", rdata, 32'h11AABEEF);

    // BUSY while selected must not open a data phase
    HSEL0  = 1'b1;
    HTRANS = 2'b01;
    @(negedge HCLK);
    checkOutput("busy_hready", {31'b0, HREADY0}, 32'd1);
    checkOutput("busy_hresp", {30'b0, HRESP0}, 32'd0);
    HSEL0  = 1'b0;
    HTRANS = 2'b00;

    // forwarding of a write into the immediately following read
    applyStimulus(0, 1'b1, 32'h30, 3'd2, 32'hCAFEF00D, waits, firstResp, lastResp, rdata);
    applyStimulus(0, 1'b0, 32'h30, 3'd2, 32'h0, waits, firstResp, lastResp, rdata);
    checkOutput("fwd_waits", waits, 0);
    checkOutput("fwd_rd", rdata, 32'hCAFEF00D);

    // illegal accesses must not disturb word 0
    applyStimulus(0, 1'b1, 32'h0, 3'd2, 32'h5A5A5A5A, waits, firstResp, lastResp, rdata);
    applyStimulus(0, 1'b1, 32'h1000, 3'd2, 32'h0BADBAD0, waits, firstResp, lastResp, rdata);
    checkOutput("err_range_waits", waits, 1);
    checkOutput("err_range_resp1", {30'b0, firstResp}, 32'd1);
    checkOutput("err_range_resp2", {30'b0, lastResp}, 32'd1);
    applyStimulus(0, 1'b1, 32'h2, 3'd2, 32'hFFFFFFFF, waits, firstResp, lastResp, rdata);
    checkOutput("err_align_waits", waits, 1);
    checkOutput("err_align_resp1", {30'b0, firstResp}, 32'd1);
    checkOutput("err_align_resp2", {30'b0, lastResp}, 32'd1);
    applyStimulus(0, 1'b1, 32'h0, 3'd3, 32'h12121212, waits, firstResp, lastResp, rdata);
    checkOutput("err_size_waits", waits, 1);
    checkOutput("err_size_resp1", {30'b0, firstResp}, 32'd1);
    checkOutput("err_size_resp2", {30'b0, lastResp}, 32'd1);
    @(negedge HCLK);
    checkOutput("err_idle_hready", {31'b0, HREADY0}, 32'd1);
    checkOutput("err_idle_hresp", {30'b0, HRESP0}, 32'd0);
    applyStimulus(0, 1'b0, 32'h0, 3'd2, 32'h0, waits, firstResp, lastResp, rdata);
    checkOutput("err_mem_kept", rdata, 32'h5A5A5A5A);
    checkOutput("err_rd_resp", {30'b0, lastResp}, 32'd0);

    // two wait states
    applyStimulus(2, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, waits, firstResp, lastResp, rdata);
    checkOutput("ws2_wr_waits", waits, 2);
    applyStimulus(2, 1'b0, 32'h10, 3'd2, 32'h0, waits, firstResp, lastResp, rdata);
    checkOutput("ws2_rd_waits", waits, 2);
    checkOutput("ws2_rd_data", rdata, 32'hDEADBEEF);
    checkOutput("ws2_rd_resp", {30'b0, lastResp}, 32'd0);

    // reset during the wait of a write must drop it
    applyStimulus(2, 1'b1, 32'h40, 3'd2, 32'h12345678, waits, firstResp, lastResp, rdata);
    HSEL2  = 1'b1;
    HADDR  = 32'h40;
    HWRITE = 1'b1;
    HSIZE  = 3'd2;
    HTRANS = 2'b10;
    @(posedge HCLK);
    @(negedge HCLK);
    HSEL2  = 1'b0;
    HTRANS = 2'b00;
    HWDATA = 32'hFFFFFFFF;
    checkOutput("rstmid_wait", {31'b0, HREADY2}, 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK);
    @(negedge HCLK);
    HRESET = 1'b0;
    checkOutput("rstmid_hready", {31'b0, HREADY2}, 32'd1);
    checkOutput("rstmid_hresp", {30'b0, HRESP2}, 32'd0);
    checkOutput("rstmid_hrdata", HRDATA2, 32'h0);
    applyStimulus(2, 1'b0, 32'h40, 3'd2, 32'h0, waits, firstResp, lastResp, rdata);
    checkOutput("rstmid_mem_kept", rdata, 32'h12345678);

    @(negedge HCLK);
    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
